// File: rtl/nn_pkg.sv
// nn_pkg: shared types and helpers for the neuron_mac slice.
//   mac_state_t  - control FSM states of neuron_mac.
//   MIN_ACC_LEN  - smallest accumulator width that cannot overflow for a
//                  given word width and number of products (plus bias).
//   relu         - clamps a negative value to zero; works on a 64-bit signed
//                  container so callers sign-extend into it and truncate back.
package nn_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

  // Width of the container relu operates on; accumulators must be narrower.
  localparam int RELU_WIDTH = 64;

  function automatic int MIN_ACC_LEN(input int word, input int n);
    return 2 * word + $clog2(n) + 1;
  endfunction

  function automatic logic signed [RELU_WIDTH-1:0] relu(input logic signed [RELU_WIDTH-1:0] v);
    return (v < 0) ? '0 : v;
  endfunction

endpackage

// File: rtl/neuron_mac_mac_unit.sv
// mac_unit: datapath of neuron_mac.
//   Registers the accepted activation (x_q) and a one-cycle-delayed enable
//   (mac_en_q) so the product lines up with the registered BRAM read data.
//   Ports:
//     clk_i, reset_ni  clock / asynchronous active-low reset
//     clear_i          zero the accumulator (start of a dot product)
//     accept_i         an activation is being accepted this cycle
//     x_data_i         signed activation
//     w_data_i         signed weight from the BRAM (valid the cycle after accept)
//     acc_next_o       accumulator value including this cycle's product
module mac_unit #(
  parameter int WORD_LEN = 8,
  parameter int ACC_LEN  = 24
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       clear_i,
  input  logic                       accept_i,
  input  logic signed [WORD_LEN-1:0] x_data_i,
  input  logic signed [WORD_LEN-1:0] w_data_i,
  output logic signed [ACC_LEN-1:0]  acc_next_o
);

  logic signed [WORD_LEN-1:0]   x_q_reg;
  logic                         mac_en_q_reg;
  logic signed [ACC_LEN-1:0]    acc_reg;
  logic signed [2*WORD_LEN-1:0] prod;
  logic signed [ACC_LEN-1:0]    prod_ext;

  assign prod     = x_q_reg * w_data_i;
  assign prod_ext = {{(ACC_LEN - 2 * WORD_LEN){prod[2*WORD_LEN-1]}}, prod};

  // The weight bus is only meaningful the cycle after an accept, so the
  // product is gated rather than trusting the BRAM to return zero.
  assign acc_next_o = mac_en_q_reg ? (acc_reg + prod_ext) : acc_reg;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q_reg      <= '0;
      mac_en_q_reg <= 1'b0;
      acc_reg      <= '0;
    end else begin
      if (accept_i) begin
        x_q_reg <= x_data_i;
      end
      mac_en_q_reg <= accept_i;
      acc_reg      <= clear_i ? '0 : acc_next_o;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// neuron_mac: single-neuron dot-product engine fed by a weight BRAM.
//   For each accepted activation a BRAM read is issued at BASE_ADDR+count;
//   the product is accumulated when the registered read data arrives. After
//   N_INPUTS products the bias is added, ReLU optionally applied, and the
//   result is held on a valid/ready port.
//   Ports:
//     clk_i, reset_ni              clock / asynchronous active-low reset
//     start_i, bias_i              begin a dot product (IDLE only), its bias
//     x_valid_i, x_data_i, x_ready_o  activation stream
//     bram_ena_o, bram_wr_ena_o, bram_addr_o, bram_data_o, bram_data_i
//                                  BRAM read port (this block never writes)
//     y_valid_o, y_data_o, y_ready_i  result port
//     busy_o                       high whenever not IDLE
module neuron_mac
  import nn_pkg::*;
#(
  parameter int ADDR_LEN  = 8,
  parameter int WORD_LEN  = 8,
  parameter int N_INPUTS  = 16,
  parameter int ACC_LEN   = 24,
  parameter int BASE_ADDR = 0,
  parameter int RELU_EN   = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       start_i,
  input  logic signed [WORD_LEN-1:0] bias_i,
  input  logic                       x_valid_i,
  input  logic signed [WORD_LEN-1:0] x_data_i,
  output logic                       x_ready_o,
  output logic                       bram_ena_o,
  output logic                       bram_wr_ena_o,
  output logic [ADDR_LEN-1:0]        bram_addr_o,
  output logic [WORD_LEN-1:0]        bram_data_o,
  input  logic signed [WORD_LEN-1:0] bram_data_i,
  output logic                       y_valid_o,
  output logic signed [ACC_LEN-1:0]  y_data_o,
  input  logic                       y_ready_i,
  output logic                       busy_o
);

  if (ACC_LEN < MIN_ACC_LEN(WORD_LEN, N_INPUTS) || ACC_LEN >= RELU_WIDTH ||
      N_INPUTS < 1 || N_INPUTS > (1 << ADDR_LEN)) begin : g_bad_params
    $fatal(1, "neuron_mac: ACC_LEN or N_INPUTS out of range");
  end

  localparam logic [ADDR_LEN-1:0] LAST_COUNT = ADDR_LEN'(N_INPUTS - 1);
  localparam logic [ADDR_LEN-1:0] BASE       = ADDR_LEN'(BASE_ADDR);

  mac_state_t                 state_reg, state_next;
  logic [ADDR_LEN-1:0]        count_reg;
  logic signed [WORD_LEN-1:0] bias_q_reg;
  logic signed [ACC_LEN-1:0]  y_data_reg;
  logic                       y_valid_reg;
  logic                       clear;
  logic                       accept;
  logic signed [ACC_LEN-1:0]  acc_next;
  logic signed [ACC_LEN-1:0]  sum;
  logic signed [ACC_LEN-1:0]  result;

  always_comb begin
    state_next = state_reg;
    x_ready_o  = 1'b0;
    clear      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          clear      = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        x_ready_o = 1'b1;
        if (x_valid_i && count_reg == LAST_COUNT) begin
          state_next = DRAIN;
        end
      end
      DRAIN: state_next = DONE;
      DONE: begin
        if (y_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept        = x_ready_o && x_valid_i;
  assign bram_ena_o    = accept;
  assign bram_addr_o   = BASE + count_reg;  // wraps modulo 2**ADDR_LEN
  assign bram_wr_ena_o = 1'b0;
  assign bram_data_o   = '0;
  assign busy_o        = (state_reg != IDLE);
  assign y_valid_o     = y_valid_reg;
  assign y_data_o      = y_data_reg;

  // In DRAIN the last product is still in flight, so the result is formed
  // from acc_next to reach y_valid two cycles after the final accept.
  assign sum    = acc_next + {{(ACC_LEN - WORD_LEN){bias_q_reg[WORD_LEN-1]}}, bias_q_reg};
  assign result = (RELU_EN != 0)
                ? ACC_LEN'(relu({{(RELU_WIDTH - ACC_LEN){sum[ACC_LEN-1]}}, sum}))
                : sum;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      bias_q_reg  <= '0;
      y_data_reg  <= '0;
      y_valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (clear) begin
        count_reg  <= '0;
        bias_q_reg <= bias_i;
      end else if (accept) begin
        count_reg <= count_reg + 1'b1;
      end
      if (state_reg == DRAIN) begin
        y_data_reg  <= result;
        y_valid_reg <= 1'b1;
      end else if (state_reg == DONE && y_ready_i) begin
        y_valid_reg <= 1'b0;
      end
    end
  end

  mac_unit #(
    .WORD_LEN(WORD_LEN),
    .ACC_LEN (ACC_LEN)
  ) u_mac (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .clear_i   (clear),
    .accept_i  (accept),
    .x_data_i  (x_data_i),
    .w_data_i  (bram_data_i),
    .acc_next_o(acc_next)
  );

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: three instances run in lockstep on the same stimulus
// (ReLU at base 16, identity at base 16, ReLU at base 254 for address wrap),
// each with its own registered-read BRAM model sharing one weight array.
module tb_neuron_mac;

  localparam int NDUT = 3;
  localparam int BASE_TBL [NDUT] = '{16, 16, 254};
  localparam int RELU_TBL [NDUT] = '{1, 0, 1};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic x_valid = 1'b0;
  logic y_ready = 1'b0;
  logic signed [7:0] bias = '0;
  logic signed [7:0] x_data = '0;

  logic              x_ready     [NDUT];
  logic              bram_ena    [NDUT];
  logic              bram_wr_ena [NDUT];
  logic [7:0]        bram_addr   [NDUT];
  logic [7:0]        bram_wdata  [NDUT];
  logic signed [7:0] bram_rdata  [NDUT];
  logic              y_valid     [NDUT];
  logic signed [23:0] y_data     [NDUT];
  logic              busy        [NDUT];

  logic signed [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    neuron_mac #(
      .ADDR_LEN (8),
      .WORD_LEN (8),
      .N_INPUTS (4),
      .ACC_LEN  (24),
      .BASE_ADDR(BASE_TBL[gi]),
      .RELU_EN  (RELU_TBL[gi])
    ) dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .start_i      (start),
      .bias_i       (bias),
      .x_valid_i    (x_valid),
      .x_data_i     (x_data),
      .x_ready_o    (x_ready[gi]),
      .bram_ena_o   (bram_ena[gi]),
      .bram_wr_ena_o(bram_wr_ena[gi]),
      .bram_addr_o  (bram_addr[gi]),
      .bram_data_o  (bram_wdata[gi]),
      .bram_data_i  (bram_rdata[gi]),
      .y_valid_o    (y_valid[gi]),
      .y_data_o     (y_data[gi]),
      .y_ready_i    (y_ready),
      .busy_o       (busy[gi])
    );

    // BRAM drives 0 when not enabled.
    always @(posedge clk) begin
      bram_rdata[gi] <= bram_ena[gi] ? mem[bram_addr[gi]] : 8'sd0;
    end
  end

  task automatic check_value(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_weights(input logic signed [7:0] w0, input logic signed [7:0] w1,
                             input logic signed [7:0] w2, input logic signed [7:0] w3);
    logic signed [7:0] w [4];
    w = '{w0, w1, w2, w3};
    for (int j = 0; j < 4; j++) begin
      mem[16 + j]          = w[j];
      mem[(254 + j) % 256] = w[j];
    end
  endtask

  // Outputs expected while idle or held in reset.
  task automatic check_quiet(input string tag, input bit check_data);
    for (int i = 0; i < NDUT; i++) begin
      check_value($sformatf("%s x_ready[%0d]", tag, i), x_ready[i], 0);
      check_value($sformatf("%s bram_ena[%0d]", tag, i), bram_ena[i], 0);
      check_value($sformatf("%s y_valid[%0d]", tag, i), y_valid[i], 0);
      check_value($sformatf("%s busy[%0d]", tag, i), busy[i], 0);
      check_value($sformatf("%s wr_ena[%0d]", tag, i), bram_wr_ena[i], 0);
      check_value($sformatf("%s wdata[%0d]", tag, i), bram_wdata[i], 0);
      if (check_data) begin
        check_value($sformatf("%s addr[%0d]", tag, i), bram_addr[i], BASE_TBL[i]);
        check_value($sformatf("%s y_data[%0d]", tag, i), y_data[i], 0);
      end
    end
  endtask

  // One dot product from IDLE back to IDLE. vpat bit c is x_valid in RUN
  // cycle c; the activation value is the same for every accept.
  task automatic run_dot(input string name, input logic signed [7:0] b,
                         input logic signed [7:0] x, input logic [15:0] vpat,
                         input int plen, input int stall, input bit pulse_start,
                         input logic signed [63:0] exp_relu,
                         input logic signed [63:0] exp_lin);
    int k;
    logic signed [63:0] exp_y;
    bias  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    bias  = 8'sh7f;  // bias must have been sampled already
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_value($sformatf("%s run busy[%0d]", name, i), busy[i], 1);
      check_value($sformatf("%s run x_ready[%0d]", name, i), x_ready[i], 1);
    end
    k = 0;
    for (int c = 0; c < plen; c++) begin
      x_valid = vpat[c];
      x_data  = vpat[c] ? x : 8'sh55;
      start   = pulse_start && (c == 1);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        check_value($sformatf("%s ena c%0d[%0d]", name, c, i), bram_ena[i], vpat[c]);
        if (vpat[c])
          check_value($sformatf("%s addr k%0d[%0d]", name, k, i), bram_addr[i],
                      (BASE_TBL[i] + k) % 256);
      end
      if (vpat[c]) k++;
      tick();
    end
    x_valid = 1'b0;
    start   = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_value($sformatf("%s drain x_ready[%0d]", name, i), x_ready[i], 0);
      check_value($sformatf("%s drain y_valid[%0d]", name, i), y_valid[i], 0);
      check_value($sformatf("%s drain busy[%0d]", name, i), busy[i], 1);
    end
    tick();
    for (int s = 0; s <= stall; s++) begin
      y_ready = (s == stall);
      start   = pulse_start && (s != stall);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        exp_y = (RELU_TBL[i] != 0) ? exp_relu : exp_lin;
        check_value($sformatf("%s done%0d y_valid[%0d]", name, s, i), y_valid[i], 1);
        check_value($sformatf("%s done%0d y_data[%0d]", name, s, i), y_data[i], exp_y);
      end
      tick();
    end
    y_ready = 1'b0;
    start   = 1'b0;
    #1;
    check_quiet({name, " post"}, 1'b0);
    tick();
    tick();
    check_quiet({name, " idle"}, 1'b0);
  endtask

  initial begin
    set_weights(8'sd1, 8'sd2, 8'sd3, 8'sd4);
    repeat (2) @(posedge clk);
    #2;
    check_quiet("reset", 1'b1);
    reset_n = 1'b1;
    tick();
    check_quiet("idle0", 1'b1);

    // 1*1+1*2+1*3+1*4+5 = 15
    run_dot("basic", 8'sd5, 8'sd1, 16'b1111, 4, 0, 1'b0, 15, 15);

    // 2*(-3)*4 = -24; clamped to 0 under ReLU
    set_weights(-8'sd3, -8'sd3, -8'sd3, -8'sd3);
    run_dot("relu", 8'sd0, 8'sd2, 16'b1111, 4, 0, 1'b0, 0, -24);

    // -128*(1+2+3+4) = -1280 with gaps in the valid stream
    set_weights(8'sd1, 8'sd2, 8'sd3, 8'sd4);
    run_dot("stall", 8'sd0, 8'sh80, 16'b1011001, 7, 0, 1'b0, 0, -1280);

    // Back-pressure for 5 cycles, start pulses in RUN and DONE ignored
    run_dot("bp", 8'sd5, 8'sd1, 16'b1111, 4, 5, 1'b1, 15, 15);

    // Reset after two accepts
    bias  = 8'sd5;
    start = 1'b1;
    tick();
    start   = 1'b0;
    x_valid = 1'b1;
    x_data  = 8'sd1;
    tick();
    tick();
    reset_n = 1'b0;
    x_valid = 1'b0;
    #1;
    check_quiet("abort", 1'b1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_quiet("abort rel", 1'b1);
    tick();
    tick();
    check_quiet("abort idle", 1'b1);
    run_dot("rerun", 8'sd5, 8'sd1, 16'b1111, 4, 0, 1'b0, 15, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
